// File: rtl/lp_pool1d_window_sched.sv
// Window sequencer for the Lp-pool 1D datapath: pads each row with zeros at both
// ends and issues one KERNEL_SIZE-wide window per output position, stepping by STRIDE.
module lp_pool1d_window_sched #(
    parameter int DATA_IN_0_PRECISION_0       = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int KERNEL_SIZE                 = 2,
    parameter int STRIDE                      = 2,
    parameter int PADDING                     = 0,
    localparam int ROW_W = (DATA_IN_0_TENSOR_SIZE_DIM_1 > 1) ? $clog2(DATA_IN_0_TENSOR_SIZE_DIM_1) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0,
    input  logic                             data_in_0_valid,
    output logic                             data_in_0_ready,
    output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [KERNEL_SIZE-1:0],
    output logic                             data_out_0_valid,
    input  logic                             data_out_0_ready,
    output logic                             data_out_0_last,
    output logic [ROW_W-1:0]                 data_out_0_row
);
    localparam int W       = DATA_IN_0_PRECISION_0;
    localparam int IN_LEN  = DATA_IN_0_TENSOR_SIZE_DIM_0;
    localparam int ROWS    = DATA_IN_0_TENSOR_SIZE_DIM_1;
    localparam int K       = KERNEL_SIZE;
    localparam int S       = STRIDE;
    localparam int P       = PADDING;
    localparam int PAD_LEN = IN_LEN + 2 * P;
    localparam int OUT_LEN = (PAD_LEN - K) / S + 1;
    localparam int POS_W   = $clog2(PAD_LEN + 1);
    localparam int WIN_W   = $clog2(OUT_LEN + 1);
    localparam int GAP_W   = $clog2(S + 1);

    if (PAD_LEN < K) begin : g_len_chk
        $error("lp_pool1d_window_sched: IN_LEN + 2*PADDING must be >= KERNEL_SIZE");
    end
    if (P >= K) begin : g_pad_chk
        $error("lp_pool1d_window_sched: PADDING must be < KERNEL_SIZE");
    end

    typedef enum logic [1:0] {HEAD, BODY, TAIL} state_t;
    localparam state_t RST_STATE = (P > 0) ? HEAD : BODY;

    state_t           state_reg, state_next;
    logic [POS_W-1:0] pos_reg, pos_next;
    logic [ROW_W-1:0] row_reg;
    logic [GAP_W-1:0] gap_reg;
    logic [WIN_W-1:0] widx_reg;
    logic [W-1:0]     win_reg [K-1:0];
    logic             valid_reg, last_reg;
    logic [ROW_W-1:0] row_out_reg;

    logic         free, advance, row_end, eligible, emit, head_next;
    logic [W-1:0] sample;

    assign free    = !valid_reg || data_out_0_ready;
    assign advance = free && (state_reg != BODY || data_in_0_valid);
    assign row_end = (pos_reg == POS_W'(PAD_LEN - 1));
    // gap_reg counts the positions still to skip before the next window start
    assign emit    = eligible && (gap_reg == '0);

    if (K > 1) begin : g_elig
        assign eligible = (pos_reg >= POS_W'(K - 1));
    end else begin : g_elig_k1
        assign eligible = 1'b1;
    end

    if (P > 0) begin : g_head
        assign head_next = (pos_next < POS_W'(P));
    end else begin : g_nohead
        assign head_next = 1'b0;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= RST_STATE;
        else     state_reg <= state_next;
    end

    // next-state logic: the phase of a row follows the position of the next sample
    always_comb begin
        pos_next   = pos_reg;
        state_next = state_reg;
        if (advance) begin
            pos_next = row_end ? '0 : pos_reg + 1'b1;
            if (head_next)                          state_next = HEAD;
            else if (pos_next < POS_W'(P + IN_LEN)) state_next = BODY;
            else                                    state_next = TAIL;
        end
    end

    // output logic
    always_comb begin
        data_in_0_ready = (state_reg == BODY) && free;
        sample          = (state_reg == BODY) ? data_in_0 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_reg     <= '0;
            row_reg     <= '0;
            gap_reg     <= '0;
            widx_reg    <= '0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
            row_out_reg <= '0;
        end else if (advance) begin
            pos_reg   <= pos_next;
            valid_reg <= emit;
            if (emit) begin
                last_reg    <= (widx_reg == WIN_W'(OUT_LEN - 1));
                row_out_reg <= row_reg;
            end
            if (row_end) begin
                row_reg  <= (row_reg == ROW_W'(ROWS - 1)) ? '0 : row_reg + 1'b1;
                gap_reg  <= '0;
                widx_reg <= '0;
            end else if (emit) begin
                gap_reg  <= GAP_W'(S - 1);
                widx_reg <= widx_reg + 1'b1;
            end else if (eligible) begin
                gap_reg  <= gap_reg - 1'b1;
            end
        end else if (data_out_0_ready) begin
            valid_reg <= 1'b0;
        end
    end

    // window shift register: newest sample enters at the top index
    for (genvar gi = 0; gi < K; gi++) begin : g_win
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                win_reg[gi] <= '0;
            end else if (advance) begin
                if (gi == K - 1) win_reg[gi] <= sample;
                else             win_reg[gi] <= win_reg[(gi < K - 1) ? gi + 1 : gi];
            end
        end
        assign data_out_0[gi] = win_reg[gi];
    end

    assign data_out_0_valid = valid_reg;
    assign data_out_0_last  = last_reg;
    assign data_out_0_row   = row_out_reg;

endmodule

// File: tb/tb_lp_pool1d_window_sched.sv
// Bench for lp_pool1d_window_sched: cycle table on a P=0 stride-gap instance, plus
// directed and random streams on a padded two-row instance checked against a window model.
module tb_lp_pool1d_window_sched;
    localparam int A_LEN = 5, A_K = 3, A_S = 2, A_P = 1, A_ROWS = 2;
    localparam int A_OUT = (A_LEN + 2 * A_P - A_K) / A_S + 1;
    localparam int B_LEN = 8, B_K = 2, B_S = 3, B_P = 0, B_ROWS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] a_din;
    logic       a_vin, a_irdy, a_oval, a_ordy, a_last;
    logic [7:0] a_dout [A_K-1:0];
    logic [0:0] a_row;

    logic [7:0] b_din;
    logic       b_vin, b_irdy, b_oval, b_ordy, b_last;
    logic [7:0] b_dout [B_K-1:0];
    logic [0:0] b_row;

    lp_pool1d_window_sched #(
        .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_TENSOR_SIZE_DIM_0(A_LEN),
        .DATA_IN_0_TENSOR_SIZE_DIM_1(A_ROWS), .KERNEL_SIZE(A_K), .STRIDE(A_S), .PADDING(A_P)
    ) dut_a (
        .clk(clk), .rst(rst), .data_in_0(a_din), .data_in_0_valid(a_vin),
        .data_in_0_ready(a_irdy), .data_out_0(a_dout), .data_out_0_valid(a_oval),
        .data_out_0_ready(a_ordy), .data_out_0_last(a_last), .data_out_0_row(a_row)
    );

    lp_pool1d_window_sched #(
        .DATA_IN_0_PRECISION_0(8), .DATA_IN_0_TENSOR_SIZE_DIM_0(B_LEN),
        .DATA_IN_0_TENSOR_SIZE_DIM_1(B_ROWS), .KERNEL_SIZE(B_K), .STRIDE(B_S), .PADDING(B_P)
    ) dut_b (
        .clk(clk), .rst(rst), .data_in_0(b_din), .data_in_0_valid(b_vin),
        .data_in_0_ready(b_irdy), .data_out_0(b_dout), .data_out_0_valid(b_oval),
        .data_out_0_ready(b_ordy), .data_out_0_last(b_last), .data_out_0_row(b_row)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    typedef struct {
        bit vin; int din; bit rdy;
        bit e_irdy; bit e_val; int e_w0; int e_w1; bit e_last; int e_row;
    } vec_t;

    function automatic vec_t mk(bit vin, int din, bit rdy, bit e_irdy, bit e_val,
                                int e_w0, int e_w1, bit e_last, int e_row);
        vec_t v;
        v.vin = vin; v.din = din; v.rdy = rdy; v.e_irdy = e_irdy; v.e_val = e_val;
        v.e_w0 = e_w0; v.e_w1 = e_w1; v.e_last = e_last; v.e_row = e_row;
        return v;
    endfunction

    typedef struct { int w0; int w1; int w2; bit last; int row; } win_t;
    win_t expq[$];
    int   a_rows_done = 0;

    // Window model: pad each row, then take K-wide slices every S positions.
    task automatic run_a(input int nrows, input int vprob, input int rprob, input bit seq);
        int   elems[$];
        int   pad[$];
        int   idx, v, budget;
        bit   stalled;
        int   h_data, h_last, h_row;
        win_t e;
        elems = {};
        for (int r = 0; r < nrows; r++) begin
            pad = {};
            for (int i = 0; i < A_P; i++) pad.push_back(0);
            for (int i = 0; i < A_LEN; i++) begin
                v = seq ? (r * A_LEN + i + 1) : int'($urandom_range(0, 255));
                elems.push_back(v);
                pad.push_back(v);
            end
            for (int i = 0; i < A_P; i++) pad.push_back(0);
            for (int w = 0; w < A_OUT; w++) begin
                e.w0 = pad[w * A_S]; e.w1 = pad[w * A_S + 1]; e.w2 = pad[w * A_S + 2];
                e.last = (w == A_OUT - 1);
                e.row = (a_rows_done + r) % A_ROWS;
                expq.push_back(e);
            end
        end
        a_rows_done += nrows;
        idx = 0; stalled = 0; h_data = 0; h_last = 0; h_row = 0;
        for (budget = 0; budget < 3000; budget++) begin
            @(posedge clk); #1;
            a_ordy = ($urandom_range(1, 100) <= rprob);
            if (idx < elems.size() && $urandom_range(1, 100) <= vprob) begin
                a_vin = 1'b1; a_din = 8'(elems[idx]);
            end else begin
                a_vin = 1'b0; a_din = 8'($urandom);
            end
            #1;
            if (stalled) begin
                check("hold_valid", int'(a_oval), 1);
                check("hold_data", int'({a_dout[2], a_dout[1], a_dout[0]}), h_data);
                check("hold_last", int'(a_last), h_last);
                check("hold_row", int'(a_row), h_row);
            end
            if (a_oval && !a_ordy) check("stall_in_ready", int'(a_irdy), 0);
            if (a_vin && a_irdy) idx++;
            if (a_oval && a_ordy) begin
                if (expq.size() == 0) begin
                    check("extra_window", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("win_w0", int'(a_dout[0]), e.w0);
                    check("win_w1", int'(a_dout[1]), e.w1);
                    check("win_w2", int'(a_dout[2]), e.w2);
                    check("win_last", int'(a_last), int'(e.last));
                    check("win_row", int'(a_row), e.row);
                end
            end
            stalled = a_oval && !a_ordy;
            h_data  = int'({a_dout[2], a_dout[1], a_dout[0]});
            h_last  = int'(a_last);
            h_row   = int'(a_row);
            if (idx == elems.size() && expq.size() == 0) break;
        end
        check("drain", expq.size() + (elems.size() - idx), 0);
        @(posedge clk); #1;
        a_vin = 1'b0;
        $display("run_a rows=%0d vprob=%0d rprob=%0d cycles=%0d", nrows, vprob, rprob, budget);
    endtask

    vec_t tbl[15];

    initial begin
        int acc;
        a_din = '0; a_vin = 1'b0; a_ordy = 1'b0;
        b_din = '0; b_vin = 1'b0; b_ordy = 1'b0;

        tbl[0]  = mk(1, 1,  1, 1, 0, 0,  0,  0, 0);
        tbl[1]  = mk(1, 2,  1, 1, 0, 0,  0,  0, 0);
        tbl[2]  = mk(1, 3,  1, 1, 1, 1,  2,  0, 0);
        tbl[3]  = mk(1, 4,  1, 1, 0, 0,  0,  0, 0);
        tbl[4]  = mk(1, 5,  1, 1, 0, 0,  0,  0, 0);
        tbl[5]  = mk(1, 6,  1, 1, 1, 4,  5,  0, 0);
        tbl[6]  = mk(1, 7,  1, 1, 0, 0,  0,  0, 0);
        tbl[7]  = mk(1, 8,  1, 1, 0, 0,  0,  0, 0);
        tbl[8]  = mk(0, 0,  1, 1, 1, 7,  8,  1, 0);
        tbl[9]  = mk(1, 11, 1, 1, 0, 0,  0,  0, 0);
        tbl[10] = mk(1, 12, 1, 1, 0, 0,  0,  0, 0);
        tbl[11] = mk(1, 13, 0, 0, 1, 11, 12, 0, 1);
        tbl[12] = mk(1, 13, 0, 0, 1, 11, 12, 0, 1);
        tbl[13] = mk(1, 13, 1, 1, 1, 11, 12, 0, 1);
        tbl[14] = mk(0, 0,  1, 1, 0, 0,  0,  0, 0);

        repeat (3) @(posedge clk);
        #2;
        check("rst_a_valid", int'(a_oval), 0);
        check("rst_a_in_ready", int'(a_irdy), 0);
        check("rst_a_window", int'({a_dout[2], a_dout[1], a_dout[0]}), 0);
        check("rst_a_last", int'(a_last), 0);
        check("rst_a_row", int'(a_row), 0);
        check("rst_b_valid", int'(b_oval), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("b_body_ready", int'(b_irdy), 1);
        check("a_head_ready", int'(a_irdy), 0);

        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            b_vin = tbl[i].vin; b_din = 8'(tbl[i].din); b_ordy = tbl[i].rdy;
            #1;
            $display("vec %0d: vin=%0d din=%0d rdy=%0d -> in_ready=%0d valid=%0d win=(%0d,%0d) last=%0d row=%0d",
                     i, b_vin, b_din, b_ordy, b_irdy, b_oval, b_dout[0], b_dout[1], b_last, b_row);
            check("vec_in_ready", int'(b_irdy), int'(tbl[i].e_irdy));
            check("vec_valid", int'(b_oval), int'(tbl[i].e_val));
            if (tbl[i].e_val) begin
                check("vec_w0", int'(b_dout[0]), tbl[i].e_w0);
                check("vec_w1", int'(b_dout[1]), tbl[i].e_w1);
                check("vec_last", int'(b_last), int'(tbl[i].e_last));
                check("vec_row", int'(b_row), tbl[i].e_row);
            end
        end
        @(posedge clk); #1;
        b_vin = 1'b0; b_ordy = 1'b1;

        run_a(1, 100, 100, 1);
        run_a(2, 100, 100, 1);
        run_a(6, 70, 60, 0);
        run_a(3, 100, 30, 0);

        // Mid-operation reset with a window pending and stalled.
        acc = 0;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            @(posedge clk); #1;
            a_ordy = 1'b1; a_vin = 1'b1; a_din = 8'(acc + 1);
            #1;
            if (a_irdy) acc++;
        end
        @(posedge clk); #1;
        a_ordy = 1'b0; a_vin = 1'b1; a_din = 8'd3;
        @(posedge clk); #1;
        check("pre_rst_valid", int'(a_oval), 1);
        rst = 1'b1;
        #1;
        check("rst_valid_drop", int'(a_oval), 0);
        check("rst_in_ready", int'(a_irdy), 0);
        a_vin = 1'b0;
        expq.delete();
        a_rows_done = 0;
        @(negedge clk);
        rst = 1'b0;
        run_a(1, 100, 100, 1);
        run_a(3, 80, 70, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lp_pool1d_window_sched.md
Name: lp_pool1d_window_sched

Overview:
- Sequencer in front of the Lp-pool 1D datapath. Accepts a serial element stream, one element per beat, over one or more rows.
- Inserts zero padding at both ends of each row and assembles sliding windows of KERNEL_SIZE elements.
- Issues one window per output position, honouring STRIDE, with valid/ready handshakes on both sides.
- The downstream pooling datapath consumes one full window per handshake.

Parameters:
- DATA_IN_0_PRECISION_0, 8: element width in bits.
- DATA_IN_0_TENSOR_SIZE_DIM_0, 8: row length IN_LEN. Must be ≥ 1.
- DATA_IN_0_TENSOR_SIZE_DIM_1, 1: rows per frame ROWS. Must be ≥ 1.
- KERNEL_SIZE, 2: window length K. Must be ≥ 1.
- STRIDE, 2: window step S. Must be ≥ 1; S > K is legal.
- PADDING, 0: zeros added at each row end, P. Must satisfy P < K.
- Derived: OUT_LEN = (IN_LEN + 2P − K)/S + 1, integer division. Elaboration assertion that IN_LEN + 2P ≥ K.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- data_in_0, input, DATA_IN_0_PRECISION_0: stream element.
- data_in_0_valid, input, 1: element valid.
- data_in_0_ready, output, 1: element accepted when valid && ready.
- data_out_0[KERNEL_SIZE-1:0], output, DATA_IN_0_PRECISION_0 each: window; index 0 is the oldest element.
- data_out_0_valid, output, 1: window valid.
- data_out_0_ready, input, 1: window accepted when valid && ready.
- data_out_0_last, output, 1: qualifies the final window of a row.
- data_out_0_row, output, max(1,$clog2(ROWS)): row index of the current window.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - All outputs 0 and the window register zeroed.
  - pos, the position counter in the padded row, and the row counter are 0.
  - State is HEAD, or BODY when P = 0.
- Padded row: P zeros, then IN_LEN input elements, then P zeros. pos runs 0 .. IN_LEN+2P−1.
- States:
  - HEAD: inject P zeros. No input is consumed and data_in_0_ready = 0.
  - BODY: consume IN_LEN input elements.
  - TAIL: inject P zeros. No input is consumed.
- Transitions:
  - HEAD→BODY after P injections.
  - BODY→TAIL after IN_LEN accepts. When P = 0, go directly to next-row HEAD/BODY.
  - TAIL→HEAD (or BODY when P = 0) after P injections.
  - The row counter increments at end of row and wraps ROWS−1→0.
- Free condition: free = !data_out_0_valid || data_out_0_ready.
- Advance condition: advance = free && (state != BODY || data_in_0_valid). data_in_0_ready = (state == BODY) && free.
- On advance:
  - Shift the sample into data_out_0[K−1]; each element moves down one index.
  - Let p be the position of the sample just shifted in. Emit when p ≥ K−1 and (p−(K−1)) mod S == 0.
  - Emit: data_out_0_valid = 1 on the next cycle. data_out_0_last = 1 when (p−(K−1))/S == OUT_LEN−1. data_out_0_row is set to the current row.
  - Otherwise, if the pending window was accepted, clear data_out_0_valid.
- Trailing positions beyond the last full window: consumed with no emit. This covers stride gaps and remainder.
- Hold rule: while valid && !ready, data_out_0 and all sideband outputs are stable, and no shift occurs.
- Latency and throughput:
  - Latency is 1 cycle from the completing element's accept/injection to window valid.
  - Sustained rate is 1 element per cycle with ready held high. Padding injections cost 1 cycle each.
- Row boundary: pos resets to 0. The window register is not cleared; K fresh shifts precede the first emit of each row, so no stale data can appear.
- Values pass through unchanged. There is no arithmetic on the data.
- Mid-operation reset: the pending window is discarded, valid drops immediately, and the block restarts at row 0, pos 0.

Test Plan:
- IN_LEN=8, K=2, S=2, P=0; input 1..8, ready always high → windows (1,2),(3,4),(5,6),(7,8). last=1 only on (7,8). Throughput is one element per cycle.
- IN_LEN=5, K=3, S=2, P=1; input 1..5 → windows (0,1,2),(2,3,4),(4,5,0). last on the third window. data_in_0_ready=0 during the HEAD and TAIL cycles.
- IN_LEN=8, K=2, S=3, P=0; input 1..8 → windows (1,2),(4,5),(7,8). Elements 3 and 6 are accepted with no emit.
- Config of the first scenario; data_out_0_ready low for 3 cycles after the first window → (1,2) held stable, data_in_0_ready=0, no element lost. Sequence then continues correctly.
- ROWS=2, IN_LEN=4, K=2, S=2, P=0; input 1..8 back-to-back → (1,2),(3,4 last,row0),(5,6),(7,8 last,row1). Row counter then wraps to 0.
- Assert rst after 3 of 8 elements, then replay 1..8 → no window leaks from before reset. Output exactly matches the first scenario.
